// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run/step/debug controller.
// Holds the controller state encoding, the debug command opcodes and the
// default number of general-purpose registers walked by a register dump.
package cpu_dbg_pkg;

    // Controller states. Encoded in 3 bits so the value can be exported on a
    // debug port and compared against directly by checkers.
    typedef enum logic [2:0] {
        ST_HALT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP    = 3'd2,
        ST_DUMP_LD = 3'd3,
        ST_DUMP_TX = 3'd4
    } run_state_e;

    // Command opcodes on cmd_op. Code 7 is reserved and behaves as NOP.
    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_RUN   = 3'd1;
    localparam logic [2:0] CMD_STEP  = 3'd2;
    localparam logic [2:0] CMD_HALT  = 3'd3;
    localparam logic [2:0] CMD_DUMP  = 3'd4;
    localparam logic [2:0] CMD_SETBP = 3'd5;
    localparam logic [2:0] CMD_CLRBP = 3'd6;

    localparam int NREG_DEF = 32;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller for the single-cycle MIPS core.
// Gates the core commit enable, halts on a PC breakpoint and, while halted,
// streams the register file out through a valid/ready dump port.
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   cmd_valid/ready - command handshake; cmd_op selects the command,
//                     cmd_arg carries the breakpoint address for SETBP
//   pc              - current core PC
//   cpu_en          - core commit enable (PC, RF write, MemWrite)
//   reg_sel/reg_data- register file debug read port (data is combinational)
//   dump_valid/ready, dump_idx, dump_data - register dump stream
//   halted, bp_hit  - status; bp_hit is sticky until the next RUN/STEP
//   cycle_cnt       - number of cycles with cpu_en high (wraps)
//   state_dbg       - current controller state (run_state_e encoding)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The dump source holds dump_idx/dump_data stable while
// dump_valid is high and dump_ready is low; cmd_ready does not depend on
// cmd_valid.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int CW   = 32,
    localparam int IW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [31:0]   cmd_arg,
    input  logic [31:0]   pc,
    output logic          cpu_en,
    output logic [IW-1:0] reg_sel,
    input  logic [31:0]   reg_data,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [IW-1:0] dump_idx,
    output logic [31:0]   dump_data,
    output logic          halted,
    output logic          bp_hit,
    output logic [CW-1:0] cycle_cnt,
    output logic [2:0]    state_dbg
);

    run_state_e    state;
    logic [IW-1:0] idx;
    logic          skip;
    logic          bp_en;
    logic [31:0]   bp_addr;
    logic          cmd_acc;
    logic          match;

    assign cmd_ready  = (state == ST_HALT) || (state == ST_RUN);
    assign cmd_acc    = cmd_valid && cmd_ready;

    // skip masks the match for the first RUN cycle so resuming from a
    // breakpoint executes the parked instruction instead of re-triggering.
    assign match      = bp_en && (pc == bp_addr) && !skip;

    assign cpu_en     = ((state == ST_RUN) && !match) || (state == ST_STEP);
    assign halted     = (state == ST_HALT);
    assign dump_valid = (state == ST_DUMP_TX);
    assign reg_sel    = (state == ST_DUMP_LD) ? idx : '0;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_HALT;
            idx       <= '0;
            skip      <= 1'b0;
            bp_en     <= 1'b0;
            bp_addr   <= '0;
            bp_hit    <= 1'b0;
            cycle_cnt <= '0;
            dump_idx  <= '0;
            dump_data <= '0;
        end else begin
            if (cpu_en) begin
                cycle_cnt <= cycle_cnt + CW'(1);
            end

            // Breakpoint registers are writable in both HALT and RUN.
            if (cmd_acc && cmd_op == CMD_SETBP) begin
                bp_addr <= cmd_arg;
                bp_en   <= 1'b1;
            end else if (cmd_acc && cmd_op == CMD_CLRBP) begin
                bp_en   <= 1'b0;
            end

            case (state)
                ST_HALT: begin
                    if (cmd_acc) begin
                        case (cmd_op)
                            CMD_RUN: begin
                                state  <= ST_RUN;
                                skip   <= 1'b1;
                                bp_hit <= 1'b0;
                            end
                            CMD_STEP: begin
                                state  <= ST_STEP;
                                bp_hit <= 1'b0;
                            end
                            CMD_DUMP: begin
                                idx    <= '0;
                                state  <= ST_DUMP_LD;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    skip <= 1'b0;
                    if (match) begin
                        state  <= ST_HALT;
                        bp_hit <= 1'b1;
                    end else if (cmd_acc && cmd_op == CMD_HALT) begin
                        state  <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    state <= ST_HALT;
                end
                ST_DUMP_LD: begin
                    dump_data <= reg_data;
                    dump_idx  <= idx;
                    state     <= ST_DUMP_TX;
                end
                ST_DUMP_TX: begin
                    if (dump_ready) begin
                        if (idx == IW'(NREG - 1)) begin
                            state <= ST_HALT;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= ST_DUMP_LD;
                        end
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/breakpoint controller for the single-cycle MIPS core. It gates the core's state-commit enable, so PC, register file and data memory advance only when it allows. It stops the core on a PC breakpoint. While the core is halted, it walks the register file's debug read port (`reg_sel`/`reg_data`) and streams all 32 GPRs out over a valid/ready port. It sits between the board/debug command source and the CPU top level.

## Interface
Parameters:
- `NREG`, default 32: number of GPRs dumped; `reg_sel` width is $clog2(NREG).
- `CW`, default 32: width of the executed-cycle counter.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: command strobe.
- `cmd_ready`, out, 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`, in, 3: 0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 DUMP, 5 SETBP, 6 CLRBP, 7 reserved (treated as NOP).
- `cmd_arg`, in, 32: breakpoint address for SETBP.
- `pc`, in, 32: current core PC.
- `cpu_en`, out, 1: core commit enable, gating PC update, RF write and MemWrite.
- `reg_sel`, out, 5: RF debug read select.
- `reg_data`, in, 32: RF debug read data; combinational from `reg_sel`.
- `dump_valid`, out, 1: dump word valid.
- `dump_ready`, in, 1: dump sink ready.
- `dump_idx`, out, 5: register number of the current dump word.
- `dump_data`, out, 32: register value.
- `halted`, out, 1: high in HALT.
- `bp_hit`, out, 1: sticky breakpoint flag.
- `cycle_cnt`, out, CW: count of cycles with `cpu_en=1`.

## Operation
- States: HALT, RUN, STEP, DUMP_LD, DUMP_TX. Reset state is HALT.
- Reset values: `cpu_en=0`, `halted=1`, `bp_hit=0`, `bp_en=0`, `bp_addr=0`, `cycle_cnt=0`, `reg_sel=0`, `dump_valid=0`, `dump_idx=0`, `dump_data=0`.
- `cmd_ready` is 1 in HALT and RUN, and 0 in STEP, DUMP_LD and DUMP_TX.
- Commands accepted in HALT:
  - RUN: go to RUN and set the skip flag.
  - STEP: go to STEP.
  - DUMP: set idx to 0 and go to DUMP_LD.
  - HALT: no-op.
  - RUN and STEP also clear `bp_hit`.
- Commands accepted in RUN:
  - HALT: go to HALT.
  - RUN, STEP, DUMP: accepted and dropped.
- SETBP (HALT or RUN): `bp_addr<=cmd_arg`, `bp_en<=1`. CLRBP: `bp_en<=0`.
- Breakpoint match: `bp_en && pc==bp_addr && !skip`.
  - In RUN, a match forces `cpu_en=0` that cycle, so the instruction at `bp_addr` is not executed.
  - On a match: next state HALT, and `bp_hit<=1`.
- Skip flag: set on RUN acceptance, cleared after the first RUN cycle. A RUN issued while parked on the breakpoint therefore executes that instruction.
- `cpu_en`: `(RUN && !match) || STEP`. It is combinational from state, `pc` and the breakpoint registers.
- STEP lasts exactly one cycle with `cpu_en=1`, ignores the breakpoint, then returns to HALT.
- DUMP_LD: `reg_sel=idx`; capture `dump_data<=reg_data` and `dump_idx<=idx`; next state DUMP_TX.
- DUMP_TX: `dump_valid=1`, holding `dump_data` and `dump_idx` stable until `dump_ready`. On handshake:
  - if idx==NREG-1, go to HALT;
  - else idx++ and go to DUMP_LD.
- `cycle_cnt`: +1 on every cycle with `cpu_en=1`; wraps from all-ones to 0.

## Timing
- Command accepted at edge k: the new state and its `cpu_en` take effect in the cycle after edge k.
- HALT accepted at edge k: the instruction executing in the cycle before edge k commits (`cpu_en` was 1). `cpu_en=0` from then on.
- Breakpoint: `cpu_en` drops in the same cycle `pc` equals `bp_addr`. `halted` and `bp_hit` rise after the next edge.
- Dump rate: minimum 2 cycles per register, so 64 cycles for a full dump with `dump_ready` held at 1. Backpressure stalls in DUMP_TX indefinitely.
- `cpu_en=0` throughout DUMP, so `reg_data` is stable.
- SETBP in RUN takes effect for the comparison in the cycle after acceptance.
- Async reset mid-RUN or mid-DUMP: all outputs return to reset values immediately; a partial dump is abandoned without a final beat.

## Structure
- Shared package `cpu_dbg_pkg` holds:
  - the state enum;
  - the `cmd_op` codes (CMD_NOP through CMD_CLRBP);
  - constant `NREG_DEF=32`.
- Single module. The dump walker is small enough to stay inline; no sub-module.

## Test plan
- Reset, then STEP ×3 with `pc` advancing 0→4→8: `cpu_en` pulses exactly three single cycles, `cycle_cnt=3`, `halted=1` after each step.
- SETBP 0x0000_0010, then RUN with `pc` advancing by 4 per enabled cycle: `cpu_en=0` when `pc=0x10`, `halted=1`, `bp_hit=1`, `cycle_cnt=4`.
- From that halt, RUN: the instruction at 0x10 executes (`pc` goes to 0x14), no re-trigger, `bp_hit` cleared.
- DUMP with the RF model returning `reg_data = 0x100 + reg_sel` and `dump_ready=1`: 32 beats, idx 0..31, data 0x100..0x11F, 64 cycles total, then HALT.
- DUMP with `dump_ready` toggling 1/0 and held 0 for 10 cycles at idx 5: data and index stay stable while stalled, no beat lost or duplicated.
- Assert reset during RUN and during DUMP at idx 7: immediate HALT, `cpu_en=0`, `dump_valid=0`, `cycle_cnt=0`, `bp_en=0`.
